// File: rtl/isqrt_rr_scheduler.sv
// isqrt_rr_scheduler
//   Shares one pipelined isqrt unit among N_REQ requesters. Each cycle at most
//   one pending request is chosen round-robin and issued; the owner index is
//   pushed into an in-order tag FIFO and used to route each returning root.
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_vld/req_x/req_rdy  per-requester valid, radicand (32b each), one-hot accept
//   rsp_vld/rsp_y          registered one-hot result strobe and 16b root
//   isqrt_x_vld/isqrt_x    issue strobe and radicand towards isqrt
//   isqrt_y_vld/isqrt_y    in-order result from isqrt (no backpressure)
//   inflight               issued-but-unreturned count
//   err_orphan             sticky: result arrived with no outstanding tag
module isqrt_rr_scheduler #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_vld,
  input  logic [N_REQ*32-1:0]             req_x,
  output logic [N_REQ-1:0]                req_rdy,
  output logic [N_REQ-1:0]                rsp_vld,
  output logic [15:0]                     rsp_y,
  output logic                            isqrt_x_vld,
  output logic [31:0]                     isqrt_x,
  input  logic                            isqrt_y_vld,
  input  logic [15:0]                     isqrt_y,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_orphan
);

  localparam int unsigned     PW       = $clog2(N_REQ);
  localparam int unsigned     AW       = $clog2(MAX_INFLIGHT);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(MAX_INFLIGHT);
  localparam logic [PW:0]     N_REQ_W  = (PW+1)'(N_REQ);
  localparam logic [PW-1:0]   PTR_LAST = PW'(N_REQ-1);

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [15:0]    rsp_y_q, rsp_y_d;
  logic           err_q, err_d;
  logic [PW-1:0]  tag_mem_q [MAX_INFLIGHT];

  logic [31:0]    x_arr [N_REQ];
  logic [PW:0]    cand;
  logic [PW-1:0]  gnt_idx;
  logic           gnt_found;
  logic           fifo_full, fifo_empty;
  logic           can_issue, push, pop;

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      x_arr[k] = req_x[32*k +: 32];
    end
  end

  // Rotating priority search starting at ptr_q; the sum is one bit wider so
  // the wrap works for non-power-of-2 N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!gnt_found && req_vld[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  // Full blocks issue regardless of a same-cycle pop; reset forces the
  // combinational handshake low immediately.
  assign can_issue  = rst_n & gnt_found & ~fifo_full;
  assign push       = can_issue;
  assign pop        = isqrt_y_vld & ~fifo_empty;

  assign req_rdy     = can_issue ? (N_REQ'(1) << gnt_idx) : '0;
  assign isqrt_x_vld = can_issue;
  assign isqrt_x     = can_issue ? x_arr[gnt_idx] : '0;

  always_comb begin
    ptr_d     = ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rsp_vld_d = '0;
    rsp_y_d   = rsp_y_q;
    err_d     = err_q;
    if (push) begin
      ptr_d    = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PW'(1);
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rsp_vld_d = N_REQ'(1) << tag_mem_q[rd_ptr_q];
      rsp_y_d   = isqrt_y;
    end
    if (isqrt_y_vld && fifo_empty) err_d = 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_vld_q <= '0;
      rsp_y_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_y_q   <= rsp_y_d;
      err_q     <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read once the count says valid.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end

  assign rsp_vld    = rsp_vld_q;
  assign rsp_y      = rsp_y_q;
  assign inflight   = cnt_q;
  assign err_orphan = err_q;

endmodule
